// File: rtl/lcd_sequencer.sv
// HD44780-style LCD write sequencer: setup / E-high / hold timing from one down-counter.
// Optional busy-flag polling instead of a fixed wait: define LCD_BUSY_POLL_EN.
module lcd_sequencer #(
    parameter int T_SETUP = 2,
    parameter int T_EHIGH = 12,
    parameter int T_HOLD  = 2,
    parameter int T_WAIT  = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_data_out,
    output logic       LCD_data_oe,
    input  logic [7:0] LCD_data_in
);

    localparam int M1   = (T_SETUP > T_EHIGH) ? T_SETUP : T_EHIGH;
    localparam int M2   = (T_HOLD > T_WAIT) ? T_HOLD : T_WAIT;
    localparam int MAXP = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EHIGH = CW'(T_EHIGH - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_WAIT  = CW'(T_WAIT - 1);

`ifdef LCD_BUSY_POLL_EN
    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_EHIGH, W_HOLD, WAIT,
        P_SETUP, P_EHIGH, P_HOLD
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_EHIGH, W_HOLD, WAIT
    } state_t;
`endif

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          rdy_q;
    logic          e_q;
    logic          rs_q;
    logic          oe_q;
    logic [7:0]    data_q;
    logic          rw_q;
    logic          bf_q;

    // Counter helpers: decremented value and end-of-state flag
    logic [CW-1:0] cnt_d;
    logic          done_d;
    assign cnt_d  = cnt_q - CW'(1);
    assign done_d = (cnt_q == '0);

    assign cmd_ready    = rdy_q;
    assign busy         = ~rdy_q;
    assign LCD_E        = e_q;
    assign LCD_RS       = rs_q;
    assign LCD_data_out = data_q;
    assign LCD_data_oe  = oe_q;
    assign LCD_RW       = rw_q;

`ifdef LCD_BUSY_POLL_EN
    logic unused_data_in;
    assign unused_data_in = ^LCD_data_in[6:0];
`else
    logic unused_data_in;
    assign unused_data_in = ^{LCD_data_in, bf_q};
`endif

    // Sequencer FSM with all bus outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            oe_q    <= 1'b0;
            data_q  <= 8'h00;
            rw_q    <= 1'b0;
            bf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    rw_q  <= 1'b0;
                    if (cmd_valid && rdy_q) begin
                        state_q <= W_SETUP;
                        cnt_q   <= LD_SETUP;
                        rdy_q   <= 1'b0;
                        rs_q    <= cmd_rs;
                        data_q  <= cmd_data;
                        oe_q    <= 1'b1;
                        e_q     <= 1'b0;
                    end
                end
                W_SETUP: begin
                    if (done_d) begin
                        state_q <= W_EHIGH;
                        cnt_q   <= LD_EHIGH;
                        e_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                W_EHIGH: begin
                    if (done_d) begin
                        state_q <= W_HOLD;
                        cnt_q   <= LD_HOLD;
                        e_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                W_HOLD: begin
                    if (done_d) begin
                        oe_q <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
                        // E is already low here, so RW may flip with oe
                        state_q <= P_SETUP;
                        cnt_q   <= LD_SETUP;
                        rs_q    <= 1'b0;
                        rw_q    <= 1'b1;
`else
                        state_q <= WAIT;
                        cnt_q   <= LD_WAIT;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT: begin
                    if (done_d) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef LCD_BUSY_POLL_EN
                P_SETUP: begin
                    if (done_d) begin
                        state_q <= P_EHIGH;
                        cnt_q   <= LD_EHIGH;
                        e_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                P_EHIGH: begin
                    if (done_d) begin
                        state_q <= P_HOLD;
                        cnt_q   <= LD_HOLD;
                        e_q     <= 1'b0;
                        bf_q    <= LCD_data_in[7];
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                P_HOLD: begin
                    if (done_d) begin
                        if (bf_q) begin
                            state_q <= P_SETUP;
                            cnt_q   <= LD_SETUP;
                        end else begin
                            state_q <= IDLE;
                            rw_q    <= 1'b0;
                            rdy_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    e_q     <= 1'b0;
                    oe_q    <= 1'b0;
                    rw_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 The block SHALL have parameters T_SETUP, default 2, cycles from RS/RW/data valid to E rising (tAS).
REQ-002 The block SHALL have parameter T_EHIGH, default 12, cycles E is held high (PWEH).
REQ-003 The block SHALL have parameter T_HOLD, default 2, cycles RS/RW/data stay stable after E falls (tAH/tH).
REQ-004 The block SHALL have parameter T_WAIT, default 2000, fixed post-write execution wait in cycles (used only without the REQ-027 macro).
REQ-005 Ports, in order: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  command request; cmd_ready  out  1  block idle, able to accept.
REQ-007 cmd_rs  in  1  0=instruction, 1=data register; cmd_data  in  8  byte to write.
REQ-008 busy  out  1  inverse of cmd_ready.
REQ-009 LCD_E  out  1; LCD_RS  out  1; LCD_RW  out  1 (1=read); all registered outputs.
REQ-010 LCD_data_out  out  8; LCD_data_oe  out  1 (top-level tristate enable); LCD_data_in  in  8.

Function
REQ-011 States SHALL be IDLE, W_SETUP, W_EHIGH, W_HOLD, WAIT, P_SETUP, P_EHIGH, P_HOLD.
REQ-012 Command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_rs/cmd_data latched that edge; the next state is W_SETUP.
REQ-013 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE is ignored, and input changes after acceptance have no effect.
REQ-014 W_SETUP: LCD_RS=latched rs, LCD_RW=0, LCD_data_out=latched byte, LCD_data_oe=1, LCD_E=0; lasts exactly T_SETUP cycles.
REQ-015 W_EHIGH: as W_SETUP but LCD_E=1; lasts exactly T_EHIGH cycles.
REQ-016 W_HOLD: LCD_E=0, RS/RW/data/oe unchanged; lasts exactly T_HOLD cycles.
REQ-017 After W_HOLD, the block SHALL enter WAIT (LCD_data_oe=0, LCD_E=0) for exactly T_WAIT cycles, then IDLE.
REQ-018 Total write latency from acceptance edge to cmd_ready=1 SHALL be T_SETUP+T_EHIGH+T_HOLD+T_WAIT cycles.
REQ-019 A single down-counter of width clog2(max parameter)+1 SHALL time every state; it is loaded with (N-1) on entry and leaves the state when it reaches 0.
REQ-020 LCD_data_oe SHALL never be 1 while LCD_RW=1; RW SHALL change only while E=0.
REQ-021 cmd_valid asserted on the same edge that the block returns to IDLE SHALL be accepted no earlier than the following edge (cmd_ready must be observed as 1).
REQ-022 All parameters SHALL be >=1; a value of 1 gives a one-cycle state.

Reset
REQ-023 While reset=1, outputs SHALL be asynchronously forced to LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_data_out=0, LCD_data_oe=0, cmd_ready=0, busy=1.
REQ-024 On the first edge after reset deasserts, state SHALL be IDLE (cmd_ready=1, busy=0).
REQ-025 Reset mid-transfer SHALL abort immediately with E driven low in the same cycle; there is no resumption.
REQ-026 Latched rs/data and the counter SHALL reset to 0.

Configuration
REQ-027 Macro LCD_BUSY_POLL_EN: when defined, W_HOLD SHALL be followed by P_SETUP instead of WAIT, and T_WAIT SHALL be unused.
REQ-028 P_SETUP/P_EHIGH/P_HOLD SHALL use RS=0, RW=1, oe=0, E=0/1/0 for T_SETUP/T_EHIGH/T_HOLD cycles respectively.
REQ-029 LCD_data_in[7] SHALL be sampled on the last P_EHIGH cycle; after P_HOLD, the block SHALL go to P_SETUP if the sample is 1 and to IDLE if it is 0.
REQ-030 Without the macro, P_* states SHALL be absent and LCD_RW SHALL be constant 0.

Verification
REQ-031 Reset held 5 cycles, then released -> all outputs 0 during reset; cmd_ready=1 one edge after release.
REQ-032 Defaults, no macro, write rs=1 data=0x41 -> E high for 12 cycles starting 2 cycles after acceptance, data=0x41 with oe=1 for 16 cycles; cmd_ready returns after 2016 cycles.
REQ-033 Back-to-back: cmd_valid held high with data 0x01 then 0x38 -> second accepted exactly on the first edge with cmd_ready=1; no E overlap.
REQ-034 Reset asserted during W_EHIGH -> LCD_E=0 within the same cycle, and the block is in IDLE after release.
REQ-035 With LCD_BUSY_POLL_EN, LCD_data_in[7]=1 for 3 polls then 0 -> exactly 4 read E pulses with RW=1 and oe=0, then cmd_ready=1.
REQ-036 T_SETUP=T_EHIGH=T_HOLD=T_WAIT=1 -> write latency is exactly 4 cycles.
